// File: rtl/uop_buffer_store_if.sv
// Load and read bus of the uop buffer store.
//   master : loader/fetch side (drives load_* beats and uop_addr)
//   slave  : the store (drives load_ready, status, uop/uop_hit)
// Signals:
//   load_start, load_valid, load_data, load_last  -> store
//   load_ready, load_error, uop_buffer_ready, uop_count <- store
//   uop_addr -> store ; uop, uop_hit <- store (combinational read)
interface uop_buffer_store_if #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned BUNDLE_W = 64
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                load_start;
  logic                load_valid;
  logic                load_ready;
  logic [BUNDLE_W-1:0] load_data;
  logic                load_last;
  logic                load_error;
  logic                uop_buffer_ready;
  logic [AW:0]         uop_count;
  logic [AW-1:0]       uop_addr;
  logic [BUNDLE_W-1:0] uop;
  logic                uop_hit;

  modport master (
    output load_start, load_valid, load_data, load_last, uop_addr,
    input  load_ready, load_error, uop_buffer_ready, uop_count, uop, uop_hit
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, uop_addr,
    output load_ready, load_error, uop_buffer_ready, uop_count, uop, uop_hit
  );
endinterface

// File: rtl/uop_buffer_store.sv
// Storage and write side of the microcode uop buffer.
// A loader streams bundles in with valid/ready; fetch reads any slot
// combinationally. uop_buffer_ready flags that a complete, last-terminated
// program is held.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    uop_buffer_store_if.slave (load handshake, status, read port)
module uop_buffer_store #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned BUNDLE_W = 64
) (
  input logic                  clk,
  input logic                  reset,
  uop_buffer_store_if.slave    bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       count_q;
  logic                error_q;
  logic                load_ready;
  logic                buf_ready;
  logic                accept;
  logic                uop_hit;
  logic [BUNDLE_W-1:0] mem [DEPTH];

  // load_ready already excludes the load_start cycle, so a beat presented
  // alongside load_start is never accepted.
  assign accept = bus.load_valid && load_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (bus.load_start) state_d = ST_LOADING;
      end
      ST_LOADING: begin
        if (bus.load_start)                state_d = ST_LOADING;
        else if (accept && bus.load_last)  state_d = ST_READY;
      end
      ST_READY: begin
        if (bus.load_start) state_d = ST_LOADING;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    load_ready = 1'b0;
    buf_ready  = 1'b0;
    unique case (state_q)
      ST_LOADING: load_ready = (count_q < CW'(DEPTH)) && !bus.load_start;
      ST_READY:   buf_ready  = 1'b1;
      default: ;
    endcase
  end

  // Write pointer / entry count and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      error_q <= 1'b0;
    end else if (bus.load_start) begin
      count_q <= '0;
      error_q <= 1'b0;
    end else if (accept) begin
      count_q <= count_q + CW'(1);
      // Filling the last slot without load_last means the program never ended
      if (!bus.load_last && (count_q == CW'(DEPTH - 1))) error_q <= 1'b1;
    end
  end

  // Bundle storage; contents are don't-care out of reset
  always_ff @(posedge clk) begin
    if (accept) mem[count_q[AW-1:0]] <= bus.load_data;
  end

  // Combinational read; slots beyond the written count read as zero
  assign uop_hit = {1'b0, bus.uop_addr} < count_q;

  assign bus.uop              = uop_hit ? mem[bus.uop_addr] : '0;
  assign bus.uop_hit          = uop_hit;
  assign bus.load_ready       = load_ready;
  assign bus.load_error       = error_q;
  assign bus.uop_buffer_ready = buf_ready;
  assign bus.uop_count        = count_q;
endmodule

// File: tb/tb_uop_buffer_store.sv
// Randomized scoreboard bench for uop_buffer_store.
module tb_uop_buffer_store;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned BW    = 64;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uop_buffer_store_if #(.DEPTH(DEPTH), .BUNDLE_W(BW)) bus ();

  uop_buffer_store #(.DEPTH(DEPTH), .BUNDLE_W(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string         tag;
    logic          lr;
    logic          br;
    logic          er;
    logic [AW:0]   cnt;
    logic          hit;
    logic [BW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: a program is an ordered list of bundles
  logic [BW-1:0] m_mem [DEPTH];
  int            m_cnt = 0;
  bit            m_err = 0;
  bit            m_loading = 0;
  bit            m_ready = 0;
  logic [BW-1:0] prog [DEPTH];

  task automatic chk(input string tag, input string f,
                     input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", tag, f, act, req);
    end
  endtask

  // Monitor: compare every presented output snapshot against the queue
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, "load_ready",       BW'(bus.load_ready),       BW'(e.lr));
      chk(e.tag, "uop_buffer_ready", BW'(bus.uop_buffer_ready), BW'(e.br));
      chk(e.tag, "load_error",       BW'(bus.load_error),       BW'(e.er));
      chk(e.tag, "uop_count",        BW'(bus.uop_count),        BW'(e.cnt));
      chk(e.tag, "uop_hit",          BW'(bus.uop_hit),          BW'(e.hit));
      chk(e.tag, "uop",              bus.uop,                   e.data);
    end
  end

  task automatic model_reset();
    m_cnt = 0; m_err = 0; m_loading = 0; m_ready = 0;
  endtask

  // One clock of stimulus: drive, predict current outputs, advance model
  task automatic cycle(input string tag, input bit rst_n_v, input bit st,
                       input bit v, input logic [BW-1:0] d, input bit l,
                       input int addr, output bit acc);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst_n_v;
    bus.load_start = st;
    bus.load_valid = v;
    bus.load_data  = d;
    bus.load_last  = l;
    bus.uop_addr   = AW'(addr);
    if (!rst_n_v) model_reset();
    e.tag  = tag;
    e.lr   = rst_n_v && m_loading && (m_cnt < DEPTH) && !st;
    e.br   = m_ready;
    e.er   = m_err;
    e.cnt  = (AW+1)'(m_cnt);
    e.hit  = addr < m_cnt;
    e.data = e.hit ? m_mem[addr] : '0;
    sb.push_back(e);
    acc = 0;
    if (rst_n_v) begin
      if (st) begin
        m_cnt = 0; m_err = 0; m_loading = 1; m_ready = 0;
      end else if (m_loading && m_cnt < DEPTH && v) begin
        m_mem[m_cnt] = d;
        m_cnt++;
        acc = 1;
        if (l) begin
          m_loading = 0; m_ready = 1;
        end else if (m_cnt == DEPTH) begin
          m_err = 1;
        end
      end
    end
  endtask

  function automatic logic [BW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic idle(input string tag, input int addr);
    bit acc;
    cycle(tag, 1, 0, 0, rnd64(), 0, addr, acc);
  endtask

  task automatic start(input string tag);
    bit acc;
    cycle(tag, 1, 1, 0, rnd64(), 0, $urandom_range(0, DEPTH-1), acc);
  endtask

  task automatic new_prog();
    for (int i = 0; i < DEPTH; i++) prog[i] = rnd64();
  endtask

  // Stream n beats of prog; optional last on final beat; optional random valid
  task automatic load(input string tag, input int n, input bit with_last,
                      input bit rand_valid);
    bit acc;
    bit v;
    int idx = 0;
    int budget = 0;
    while (idx < n && budget < 400) begin
      v = rand_valid ? bit'($urandom_range(0, 1)) : 1'b1;
      cycle(tag, 1, 0, v, v ? prog[idx] : rnd64(), with_last && (idx == n-1),
            $urandom_range(0, DEPTH-1), acc);
      if (acc) idx++;
      budget++;
    end
    checks++;
    if (idx < n) begin
      errors++;
      $display("FAIL %s.beats actual=%0d required=%0d", tag, idx, n);
    end
  endtask

  task automatic read_all(input string tag, input int n);
    for (int a = 0; a < n; a++) idle(tag, a);
  endtask

  initial begin
    bit acc;
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0;
    bus.load_last  = 0; bus.uop_addr = '0;

    // Reset state
    cycle("reset", 0, 0, 0, '0, 0, 0, acc);
    cycle("reset", 0, 1, 1, rnd64(), 0, 5, acc);
    idle("post_reset", 0);
    cycle("valid_in_empty", 1, 0, 1, rnd64(), 1, 0, acc);

    // Three-beat program A,B,C
    new_prog();
    start("t1_start");
    load("t1_load", 3, 1, 0);
    idle("t1_rd1", 1);
    idle("t1_rd3", 3);
    cycle("t1_valid_ready", 1, 0, 1, rnd64(), 1, 2, acc);

    // Full-depth program terminated on the final slot
    new_prog();
    start("t2_start");
    load("t2_load", DEPTH, 1, 0);
    read_all("t2_rd", DEPTH);

    // Full-depth program never terminated
    new_prog();
    start("t3_start");
    load("t3_load", DEPTH, 0, 0);
    repeat (3) cycle("t3_stuck", 1, 0, 1, rnd64(), 1, $urandom_range(0, DEPTH-1), acc);
    start("t3_restart");
    idle("t3_cleared", 0);

    // Bursty valid, five-beat program
    new_prog();
    load("t4_load", 5, 1, 1);
    read_all("t4_rd", 6);

    // load_start colliding with a beat mid-load
    new_prog();
    start("t5_start");
    load("t5_pre", 2, 0, 0);
    cycle("t5_collide", 1, 1, 1, rnd64(), 0, 0, acc);
    idle("t5_after", 0);
    new_prog();
    load("t5_reload", 2, 1, 0);
    read_all("t5_rd", 3);

    // Reset between beat 2 and beat 3
    new_prog();
    start("t6_start");
    load("t6_pre", 2, 0, 0);
    cycle("t6_reset", 0, 0, 1, prog[2], 0, 0, acc);
    cycle("t6_reset", 0, 0, 1, prog[3], 0, 1, acc);
    for (int i = 0; i < 4; i++)
      cycle("t6_ignored", 1, 0, 1, rnd64(), i == 3, 0, acc);

    // Random mixed traffic
    for (int r = 0; r < 6; r++) begin
      new_prog();
      start("rnd_start");
      load("rnd_load", $urandom_range(1, DEPTH), bit'($urandom_range(0, 1)), 1);
      repeat (4) idle("rnd_rd", $urandom_range(0, DEPTH-1));
    end

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
